// File: rtl/pong_collision_ctrl.sv
// Pong collision and scoring controller.
// Samples ball/paddle coordinates on each tick and produces registered,
// single-cycle paddle/wall/point events, per-player scores and a
// game-over/winner indication.
module pong_collision_ctrl #(
  parameter int unsigned COORD_W   = 6,
  parameter int unsigned FIELD_MAX = 63,
  parameter int unsigned PADDLE_H  = 6,
  parameter int unsigned P1_X      = 2,
  parameter int unsigned P2_X      = 61,
  parameter int unsigned SCORE_W   = 3,
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] p1y,
  input  logic [COORD_W-1:0] p2y,
  input  logic               clr_scores,
  output logic [1:0]         paddle_hit,
  output logic               wall_hit,
  output logic [1:0]         point,
  output logic [SCORE_W-1:0] sc1,
  output logic [SCORE_W-1:0] sc2,
  output logic [1:0]         winner,
  output logic               game_over
);

  localparam int unsigned CW1 = COORD_W + 1;

  localparam logic [COORD_W-1:0] P1_XC   = COORD_W'(P1_X);
  localparam logic [COORD_W-1:0] P2_XC   = COORD_W'(P2_X);
  localparam logic [COORD_W-1:0] FMAX_C  = COORD_W'(FIELD_MAX);
  localparam logic [CW1-1:0]     PH_M1   = CW1'(PADDLE_H - 1);
  localparam logic [SCORE_W-1:0] WIN_C   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SC_ONE  = SCORE_W'(1);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    SERVE_WAIT = 2'd1,
    OVER       = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         paddle_hit_q, paddle_hit_d;
  logic               wall_hit_q, wall_hit_d;
  logic [1:0]         point_q, point_d;
  logic [SCORE_W-1:0] sc1_q, sc1_d;
  logic [SCORE_W-1:0] sc2_q, sc2_d;
  logic [1:0]         winner_q, winner_d;
  logic               game_over_q, game_over_d;

  // Paddle range tests carried one bit wider so a paddle near the bottom
  // wall does not wrap round to the top rows.
  logic [CW1-1:0] by_w, p1_lo, p1_hi, p2_lo, p2_hi;
  logic           in_p1, in_p2;
  logic [SCORE_W-1:0] sc1_inc, sc2_inc;

  // Combinational paddle range and score increment helpers.
  always_comb begin
    by_w    = {1'b0, by};
    p1_lo   = {1'b0, p1y};
    p1_hi   = p1_lo + PH_M1;
    p2_lo   = {1'b0, p2y};
    p2_hi   = p2_lo + PH_M1;
    in_p1   = (by_w >= p1_lo) && (by_w <= p1_hi);
    in_p2   = (by_w >= p2_lo) && (by_w <= p2_hi);
    sc1_inc = sc1_q + SC_ONE;
    sc2_inc = sc2_q + SC_ONE;
  end

  // Next-state and registered-output logic; clr_scores overrides tick.
  always_comb begin
    state_d      = state_q;
    paddle_hit_d = '0;
    wall_hit_d   = 1'b0;
    point_d      = '0;
    sc1_d        = sc1_q;
    sc2_d        = sc2_q;
    winner_d     = winner_q;
    game_over_d  = game_over_q;

    if (clr_scores) begin
      sc1_d       = '0;
      sc2_d       = '0;
      winner_d    = '0;
      game_over_d = 1'b0;
      state_d     = PLAY;
    end else if (tick) begin
      case (state_q)
        PLAY: begin
          wall_hit_d = (by == '0) || (by == FMAX_C);
          if (bx == P1_XC) begin
            if (in_p1) begin
              paddle_hit_d = 2'b01;
            end else begin
              sc2_d   = sc2_inc;
              point_d = 2'b10;
              if (sc2_inc == WIN_C) begin
                state_d     = OVER;
                winner_d    = 2'b10;
                game_over_d = 1'b1;
              end else begin
                state_d = SERVE_WAIT;
              end
            end
          end else if (bx == P2_XC) begin
            if (in_p2) begin
              paddle_hit_d = 2'b11;
            end else begin
              sc1_d   = sc1_inc;
              point_d = 2'b01;
              if (sc1_inc == WIN_C) begin
                state_d     = OVER;
                winner_d    = 2'b01;
                game_over_d = 1'b1;
              end else begin
                state_d = SERVE_WAIT;
              end
            end
          end
        end
        SERVE_WAIT: begin
          if ((bx != P1_XC) && (bx != P2_XC)) state_d = PLAY;
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLAY;
      paddle_hit_q <= '0;
      wall_hit_q   <= 1'b0;
      point_q      <= '0;
      sc1_q        <= '0;
      sc2_q        <= '0;
      winner_q     <= '0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      paddle_hit_q <= paddle_hit_d;
      wall_hit_q   <= wall_hit_d;
      point_q      <= point_d;
      sc1_q        <= sc1_d;
      sc2_q        <= sc2_d;
      winner_q     <= winner_d;
      game_over_q  <= game_over_d;
    end
  end

  assign paddle_hit = paddle_hit_q;
  assign wall_hit   = wall_hit_q;
  assign point      = point_q;
  assign sc1        = sc1_q;
  assign sc2        = sc2_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule

// File: doc/pong_collision_ctrl.md
Name: pong_collision_ctrl

Overview:
Clocked, parametrised collision and scoring controller for the pong datapath. It sits between the ball mover and the paddle movers and the display/score logic. It samples ball and paddle coordinates on each ball-update strobe and emits registered single-cycle paddle, wall and point events. It keeps per-player scores, debounces each miss so it scores exactly once, and detects end of game.

Parameters:
COORD_W, 6, width of all x/y coordinates
FIELD_MAX, 63, largest legal coordinate on either axis (top/bottom wall rows are 0 and FIELD_MAX)
PADDLE_H, 6, paddle height in rows; a paddle covers rows pNy .. pNy+PADDLE_H-1
P1_X, 2, column of the left paddle face (player 1)
P2_X, 61, column of the right paddle face (player 2); must differ from P1_X
SCORE_W, 3, score counter width
WIN_SCORE, 7, winning score; must be <= 2^SCORE_W-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  ball-update strobe; evaluation happens only on cycles with tick=1
bx  in  COORD_W  ball x
by  in  COORD_W  ball y
p1y  in  COORD_W  top row of left paddle
p2y  in  COORD_W  top row of right paddle
clr_scores  in  1  synchronous new-game request
paddle_hit  out  2  01 = left paddle hit, 11 = right paddle hit, 00 = none; 1-cycle pulse
wall_hit  out  1  ball on row 0 or FIELD_MAX; 1-cycle pulse
point  out  2  01 = player 1 scored, 10 = player 2 scored; 1-cycle pulse
sc1  out  SCORE_W  player 1 score
sc2  out  SCORE_W  player 2 score
winner  out  2  00 = none, 01 = player 1, 10 = player 2
game_over  out  1  high while in OVER

Behaviour:
- Reset (rst_n=0, asynchronous): state=PLAY. All outputs are 0.
- All outputs are registered. Events appear in the cycle after the tick cycle.
- paddle_hit, wall_hit and point are 0 on every cycle not following an evaluated tick.
- Paddle range test: in_p1 = (by >= p1y) && (by <= p1y+PADDLE_H-1). Compute it at COORD_W+1 bits so that p1y near FIELD_MAX does not wrap. in_p2 uses p2y the same way.
- States: PLAY, SERVE_WAIT, OVER.
- PLAY, on tick:
  - wall_hit = (by==0 || by==FIELD_MAX).
  - bx==P1_X && in_p1: paddle_hit=01.
  - bx==P2_X && in_p2: paddle_hit=11.
  - bx==P1_X && !in_p1: sc2 += 1, point=10, go to SERVE_WAIT.
  - bx==P2_X && !in_p2: sc1 += 1, point=01, go to SERVE_WAIT.
  - wall_hit may assert in the same cycle as paddle_hit or point. Evaluate the two independently.
- Win check: if the incremented score equals WIN_SCORE, go to OVER instead of SERVE_WAIT. Set winner (01 or 10) and game_over=1 in the same cycle as the point pulse.
- SERVE_WAIT: on tick, all event outputs are 0 and scores hold. Go to PLAY on the first tick where bx is neither P1_X nor P2_X. This stops a ball resting on a paddle column from scoring again.
- OVER:
  - Scores, winner and game_over hold.
  - Event outputs stay 0 regardless of tick.
  - Scores never exceed WIN_SCORE, so there is no counter wrap.
- clr_scores (any state) takes priority over tick:
  - next cycle: sc1=sc2=0, winner=00, game_over=0, state=PLAY.
  - event outputs are 0 in that cycle.
- Reset asserted mid-game: everything clears immediately. No pending event survives reset.
- Inputs are assumed stable during the tick cycle; they are sampled only on tick.

Test Plan:
- Reset, then tick with bx=2, by=10, p1y=8 -> next cycle paddle_hit=01, point=00, sc1=sc2=0.
- Tick with bx=61, by=0, p2y=0 -> next cycle paddle_hit=11 and wall_hit=1 together.
- Tick with bx=2, by=30, p1y=8 -> point=10, sc2=1. Three further ticks with bx=2 -> sc2 stays 1. Tick with bx=32, then bx=2 miss -> sc2=2.
- Paddle wrap: p2y=62, by=1, bx=61 -> miss, point=01, sc1=1; the range is not wrapped to row 1.
- Drive player 1 to 6 points, then a P2-side miss -> sc1=7, winner=01, game_over=1. Further missing ticks -> no point pulses and sc1 holds at 7.
- In OVER, pulse clr_scores together with tick -> sc1=sc2=0, game_over=0, no event pulses. Assert rst_n=0 asynchronously mid-SERVE_WAIT -> all outputs 0 before the next clk edge.
